// File: rtl/sseg_mux_n_if.sv
// Bundle between user logic and the seven-segment driver.
// The bright field exists only when SSEG_DIM_EN is defined.
interface sseg_mux_n_if #(
    parameter int N_DIGITS = 4
);
    logic [4*N_DIGITS-1:0] hex;
    logic [N_DIGITS-1:0]   dp;
    logic [N_DIGITS-1:0]   blank;
`ifdef SSEG_DIM_EN
    logic [2:0]            bright;
`endif
    logic [N_DIGITS-1:0]   an;
    logic [7:0]            sseg;
    logic                  frame_tick;

`ifdef SSEG_DIM_EN
    modport master (
        output hex, dp, blank, bright,
        input  an, sseg, frame_tick
    );
    modport slave (
        input  hex, dp, blank, bright,
        output an, sseg, frame_tick
    );
`else
    modport master (
        output hex, dp, blank,
        input  an, sseg, frame_tick
    );
    modport slave (
        input  hex, dp, blank,
        output an, sseg, frame_tick
    );
`endif
endinterface

// File: rtl/sseg_mux_n.sv
// N-digit multiplexed 7-seg driver: hex decode, blanking, dead time, frame snapshot.
// Optional brightness PWM enabled by defining SSEG_DIM_EN.
module sseg_mux_n #(
    parameter int N_DIGITS    = 4,
    parameter int SLOT_CYCLES = 65536,
    parameter int GAP_CYCLES  = 256
) (
    input  logic        clk,
    input  logic        reset,
    sseg_mux_n_if.slave bus
);
    localparam int IW   = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int MAXC = (SLOT_CYCLES > GAP_CYCLES) ? SLOT_CYCLES : GAP_CYCLES;
    localparam int CW   = $clog2(MAXC);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0] SLOT_LAST = CW'(SLOT_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(N_DIGITS - 1);
`ifdef SSEG_DIM_EN
    localparam int SUB = SLOT_CYCLES / 8;
`endif

    typedef enum logic {S_GAP, S_ON} state_t;

    state_t                state_q, state_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [4*N_DIGITS-1:0] hex_s_q, hex_s_d;
    logic [N_DIGITS-1:0]   dp_s_q, dp_s_d;
    logic [N_DIGITS-1:0]   blank_s_q, blank_s_d;
    logic [N_DIGITS-1:0]   an_q, an_d;
    logic [7:0]            sseg_q, sseg_d;
    logic                  tick_q, tick_d;
    logic [3:0]            nib;
    logic                  lit;
`ifdef SSEG_DIM_EN
    logic [2:0]            bright_s_q, bright_s_d;
`endif

    function automatic logic [6:0] decode(input logic [3:0] v);
        decode = 7'h7F;
        case (v)
            4'h0: decode = 7'h40;
            4'h1: decode = 7'h79;
            4'h2: decode = 7'h24;
            4'h3: decode = 7'h30;
            4'h4: decode = 7'h19;
            4'h5: decode = 7'h12;
            4'h6: decode = 7'h02;
            4'h7: decode = 7'h78;
            4'h8: decode = 7'h00;
            4'h9: decode = 7'h10;
            4'hA: decode = 7'h08;
            4'hB: decode = 7'h03;
            4'hC: decode = 7'h46;
            4'hD: decode = 7'h21;
            4'hE: decode = 7'h06;
            4'hF: decode = 7'h0E;
        endcase
    endfunction

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q + 1'b1;
        hex_s_d   = hex_s_q;
        dp_s_d    = dp_s_q;
        blank_s_d = blank_s_q;
        tick_d    = 1'b0;
`ifdef SSEG_DIM_EN
        bright_s_d = bright_s_q;
`endif
        unique case (state_q)
            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = S_ON;
                    cnt_d   = '0;
                    // Inputs are sampled once per frame so all digits agree
                    if (idx_q == '0) begin
                        hex_s_d   = bus.hex;
                        dp_s_d    = bus.dp;
                        blank_s_d = bus.blank;
                        tick_d    = 1'b1;
`ifdef SSEG_DIM_EN
                        bright_s_d = bus.bright;
`endif
                    end
                end
            end
            S_ON: begin
                if (cnt_q == SLOT_LAST) begin
                    state_d = S_GAP;
                    cnt_d   = '0;
                    idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
                end
            end
        endcase

        // Outputs are registered from next state so they move with it
        nib = hex_s_d[int'(idx_d)*4 +: 4];
        lit = (state_d == S_ON) && !blank_s_d[idx_d];
`ifdef SSEG_DIM_EN
        lit = lit && (int'(cnt_d) < (int'(bright_s_d) + 1) * SUB);
`endif
        an_d   = '1;
        sseg_d = 8'hFF;
        if (lit) begin
            an_d[idx_d] = 1'b0;
            sseg_d      = {~dp_s_d[idx_d], decode(nib)};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_GAP;
            idx_q     <= '0;
            cnt_q     <= '0;
            hex_s_q   <= '0;
            dp_s_q    <= '0;
            blank_s_q <= '0;
            an_q      <= '1;
            sseg_q    <= 8'hFF;
            tick_q    <= 1'b0;
`ifdef SSEG_DIM_EN
            bright_s_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            hex_s_q   <= hex_s_d;
            dp_s_q    <= dp_s_d;
            blank_s_q <= blank_s_d;
            an_q      <= an_d;
            sseg_q    <= sseg_d;
            tick_q    <= tick_d;
`ifdef SSEG_DIM_EN
            bright_s_q <= bright_s_d;
`endif
        end
    end

    assign bus.an         = an_q;
    assign bus.sseg       = sseg_q;
    assign bus.frame_tick = tick_q;

endmodule

// File: tb/tb_sseg_mux_n.sv
// Self-checking bench for sseg_mux_n: vector table, corner sequences, random run.
// Reference model derives outputs from edge count since reset release.
module tb_sseg_mux_n;
    localparam int N = 4;
    localparam int S = 8;
    localparam int G = 2;
    localparam int P = S + G;
    localparam int F = N * P;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    sseg_mux_n_if #(.N_DIGITS(N)) bus();

    sseg_mux_n #(
        .N_DIGITS(N),
        .SLOT_CYCLES(S),
        .GAP_CYCLES(G)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int total = 0;
    int bad = 0;
    int k = 0;

    logic [15:0] m_hex;
    logic [3:0]  m_dp;
    logic [3:0]  m_blank;
    logic [2:0]  m_bright;
    logic [6:0]  seg_tab [16];

    typedef struct {
        logic [15:0] hex;
        logic [3:0]  dp;
        logic [3:0]  blank;
        int          digit;
        logic [3:0]  an;
        logic [7:0]  sseg;
    } vec_t;
    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (k=%0d)", name, act, exp, k);
        end
    endtask

    // Expected outputs after kk edges since release, from frame arithmetic
    task automatic model(input int kk, output logic [3:0] ea,
                         output logic [7:0] es, output logic et);
        int pos, d, off, sc;
        logic on;
        pos = kk % F;
        d   = pos / P;
        off = pos % P;
        sc  = off - G;
        ea  = 4'hF;
        es  = 8'hFF;
        et  = (kk > 0) && (pos == G);
        on  = (off >= G) && !m_blank[d];
`ifdef SSEG_DIM_EN
        on = on && ((sc / (S / 8)) <= int'(m_bright));
`else
        if (sc > S) on = 1'b0;
`endif
        if (on) begin
            ea[d] = 1'b0;
            es    = {~m_dp[d], seg_tab[m_hex[d*4 +: 4]]};
        end
    endtask

    task automatic step(input string name);
        logic [3:0] ea;
        logic [7:0] es;
        logic       et;
        @(posedge clk);
        k++;
        if (k % F == G) begin
            m_hex   = bus.hex;
            m_dp    = bus.dp;
            m_blank = bus.blank;
`ifdef SSEG_DIM_EN
            m_bright = bus.bright;
`endif
        end
        #1;
        model(k, ea, es, et);
        check({name, ".an"}, 32'(bus.an), 32'(ea));
        check({name, ".sseg"}, 32'(bus.sseg), 32'(es));
        check({name, ".tick"}, 32'(bus.frame_tick), 32'(et));
    endtask

    task automatic run_to(input int tgt, input string name);
        while (k < tgt) step(name);
    endtask

    task automatic model_clear();
        k        = 0;
        m_hex    = '0;
        m_dp     = '0;
        m_blank  = '0;
        m_bright = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_async.an", 32'(bus.an), 32'hF);
        check("rst_async.sseg", 32'(bus.sseg), 32'hFF);
        check("rst_async.tick", 32'(bus.frame_tick), 32'h0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        model_clear();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        vecs[0] = '{16'h8A01, 4'h0, 4'h0, 0, 4'hE, 8'hF9};
        vecs[1] = '{16'h8A01, 4'h0, 4'h0, 1, 4'hD, 8'hC0};
        vecs[2] = '{16'h8A01, 4'h0, 4'h0, 2, 4'hB, 8'h88};
        vecs[3] = '{16'h8A01, 4'h0, 4'h0, 3, 4'h7, 8'h80};
        vecs[4] = '{16'h8A01, 4'h1, 4'h4, 0, 4'hE, 8'h79};
        vecs[5] = '{16'h8A01, 4'h1, 4'h4, 2, 4'hF, 8'hFF};
        vecs[6] = '{16'hC7E5, 4'h8, 4'h0, 3, 4'h7, 8'h46};
        vecs[7] = '{16'h9D3B, 4'h0, 4'h0, 1, 4'hD, 8'hB0};
        vecs[8] = '{16'h9D3B, 4'h0, 4'h0, 2, 4'hB, 8'hA1};

        bus.hex   = 16'h8A01;
        bus.dp    = 4'h0;
        bus.blank = 4'h0;
`ifdef SSEG_DIM_EN
        bus.bright = 3'd7;
`endif
        model_clear();

        // Reset held from time zero, then first frame timing
        #22;
        check("rst_hold.an", 32'(bus.an), 32'hF);
        check("rst_hold.sseg", 32'(bus.sseg), 32'hFF);
        check("rst_hold.tick", 32'(bus.frame_tick), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        step("rel1");
        check("rel1.an_off", 32'(bus.an), 32'hF);
        step("rel2");
        check("rel2.an", 32'(bus.an), 32'hE);
        check("rel2.sseg", 32'(bus.sseg), 32'hF9);
        check("rel2.tick", 32'(bus.frame_tick), 32'h1);
        step("rel3");
        check("rel3.tick", 32'(bus.frame_tick), 32'h0);
        run_to(2 * F + G, "seq");
        check("seq.tick40", 32'(bus.frame_tick), 32'h1);

        for (int i = 0; i < 9; i++) begin
            bus.hex   = vecs[i].hex;
            bus.dp    = vecs[i].dp;
            bus.blank = vecs[i].blank;
            do_reset();
            run_to(vecs[i].digit * P + G + 3, "vec");
            check($sformatf("vec%0d.an", i), 32'(bus.an), 32'(vecs[i].an));
            check($sformatf("vec%0d.sseg", i), 32'(bus.sseg), 32'(vecs[i].sseg));
            run_to(F + G, "vec_frame");
            check($sformatf("vec%0d.tick", i), 32'(bus.frame_tick), 32'h1);
        end

        // Mid-frame input change is hidden until the next frame
        bus.hex   = 16'h8A01;
        bus.dp    = 4'h0;
        bus.blank = 4'h0;
        do_reset();
        run_to(P + G, "snap");
        bus.hex = 16'hFFFF;
        run_to(P + G + 3, "snap");
        check("snap.d1", 32'(bus.sseg), 32'hC0);
        run_to(2 * P + G + 3, "snap");
        check("snap.d2", 32'(bus.sseg), 32'h88);
        run_to(3 * P + G + 3, "snap");
        check("snap.d3", 32'(bus.sseg), 32'h80);
        run_to(F + G + 3, "snap");
        check("snap.next", 32'(bus.sseg), 32'h8E);

        // Asynchronous reset in the middle of digit 2
        bus.hex = 16'h8A01;
        do_reset();
        run_to(2 * P + G + 3, "async");
        check("async.pre_an", 32'(bus.an), 32'hB);
        #2;
        reset = 1'b0;
        #1;
        check("async.an", 32'(bus.an), 32'hF);
        check("async.sseg", 32'(bus.sseg), 32'hFF);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        model_clear();
        run_to(G, "async_rel");
        check("async_rel.an", 32'(bus.an), 32'hE);
        check("async_rel.sseg", 32'(bus.sseg), 32'hF9);

        // Random inputs changing at random points
        do_reset();
        for (int c = 0; c < 5 * F; c++) begin
            if ($urandom_range(7) == 0) begin
                bus.hex   = 16'($urandom);
                bus.dp    = 4'($urandom);
                bus.blank = 4'($urandom);
`ifdef SSEG_DIM_EN
                bus.bright = 3'($urandom);
`endif
            end
            step("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
